// File: rtl/machine_mode_types_1_11_pkg.sv
// Shared machine-mode privilege types: trap sequencer states, event kinds,
// mcause code enums and the arbitration order used by the trap priority encoder.
package machine_mode_types_1_11_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_REDIRECT
  } trap_state_t;

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_EXC,
    KIND_INT,
    KIND_RET
  } trap_kind_t;

  typedef enum logic [4:0] {
    EXC_MAL_INSN         = 5'd0,
    EXC_FAULT_INSN       = 5'd1,
    EXC_ILLEGAL_INSN     = 5'd2,
    EXC_BREAKPOINT       = 5'd3,
    EXC_MAL_L            = 5'd4,
    EXC_FAULT_L          = 5'd5,
    EXC_MAL_S            = 5'd6,
    EXC_FAULT_S          = 5'd7,
    EXC_ENV_U            = 5'd8,
    EXC_ENV_S            = 5'd9,
    EXC_ENV_M            = 5'd11,
    EXC_FAULT_INSN_PAGE  = 5'd12,
    EXC_FAULT_LOAD_PAGE  = 5'd13,
    EXC_FAULT_STORE_PAGE = 5'd15
  } exc_code_t;

  typedef enum logic [4:0] {
    INT_SSI = 5'd1,
    INT_MSI = 5'd3,
    INT_STI = 5'd5,
    INT_MTI = 5'd7,
    INT_SEI = 5'd9,
    INT_MEI = 5'd11,
    INT_USI = 5'd0,
    INT_UTI = 5'd4,
    INT_UEI = 5'd8
  } int_code_t;

  localparam int EXC_NUM = 14;
  localparam int INT_NUM = 9;

  // Index 0 is the highest priority source.
  localparam logic [3:0] EXC_PRIO [EXC_NUM] = '{
    4'(EXC_BREAKPOINT), 4'(EXC_FAULT_INSN_PAGE), 4'(EXC_FAULT_INSN), 4'(EXC_ILLEGAL_INSN),
    4'(EXC_MAL_INSN), 4'(EXC_ENV_M), 4'(EXC_ENV_S), 4'(EXC_ENV_U), 4'(EXC_MAL_S),
    4'(EXC_MAL_L), 4'(EXC_FAULT_STORE_PAGE), 4'(EXC_FAULT_LOAD_PAGE), 4'(EXC_FAULT_S),
    4'(EXC_FAULT_L)
  };

  localparam logic [3:0] INT_PRIO [INT_NUM] = '{
    4'(INT_MEI), 4'(INT_MSI), 4'(INT_MTI), 4'(INT_SEI), 4'(INT_SSI),
    4'(INT_STI), 4'(INT_UEI), 4'(INT_USI), 4'(INT_UTI)
  };

  function automatic logic [31:0] trap_base(input logic [31:0] mtvec);
    return {mtvec[31:2], 2'b00};
  endfunction

  // Vectored interrupt target; the add wraps modulo 2^32.
  function automatic logic [31:0] trap_vector(input logic [31:0] mtvec, input logic [4:0] code);
    return trap_base(mtvec) + {25'd0, code, 2'b00};
  endfunction

endpackage

// File: rtl/priv_trap_prio_enc.sv
// Combinational trap arbiter: exceptions beat interrupts, each class resolved
// by its fixed priority order; interrupts are gated by mstatus.MIE.
module priv_trap_prio_enc
  import machine_mode_types_1_11_pkg::*;
(
  input  logic [15:0] exc_vec,
  input  logic [11:0] int_pend,
  input  logic        mstatus_mie,
  output logic        valid,
  output logic        is_int,
  output logic [4:0]  code
);

  logic unused_bits;
  assign unused_bits = ^{exc_vec[10], exc_vec[14], int_pend[2], int_pend[6], int_pend[10]};

  // Scan lowest priority first so the highest pending source is written last.
  always_comb begin
    valid  = 1'b0;
    is_int = 1'b0;
    code   = 5'd0;
    if (mstatus_mie) begin
      for (int i = INT_NUM - 1; i >= 0; i--) begin
        if (int_pend[INT_PRIO[i]]) begin
          valid  = 1'b1;
          is_int = 1'b1;
          code   = {1'b0, INT_PRIO[i]};
        end
      end
    end
    for (int i = EXC_NUM - 1; i >= 0; i--) begin
      if (exc_vec[EXC_PRIO[i]]) begin
        valid  = 1'b1;
        is_int = 1'b0;
        code   = {1'b0, EXC_PRIO[i]};
      end
    end
  end

endmodule

// File: rtl/priv_trap_sequencer.sv
// Machine-mode trap entry/return sequencer: latch the winning event, wait for
// the pipeline to drain, commit CSR updates in one cycle, then redirect fetch.
module priv_trap_sequencer
  import machine_mode_types_1_11_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [15:0] exc_vec,
  input  logic [31:0] mip,
  input  logic [31:0] mie,
  input  logic        mstatus_mie,
  input  logic        mstatus_mpie,
  input  logic        mret,
  input  logic        pipe_clear,
  input  logic [31:0] epc,
  input  logic [31:0] mtval_in,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        busy,
  output logic        intr,
  output logic        mcause_rup,
  output logic        mepc_rup,
  output logic        mtval_rup,
  output logic        mstatus_rup,
  output logic [31:0] mcause_next,
  output logic [31:0] mepc_next,
  output logic [31:0] mtval_next,
  output logic        mstatus_mie_next,
  output logic        mstatus_mpie_next,
  output logic        insert_pc,
  output logic [31:0] priv_pc
);

  trap_state_t state_q;
  trap_kind_t  kind_q;
  logic [4:0]  code_q;
  logic [31:0] epc_q;
  logic [31:0] mtval_q;

  logic        enc_valid;
  logic        enc_is_int;
  logic [4:0]  enc_code;
  logic [11:0] int_pend;
  logic        event_det;
  logic        unused_hi;

  assign int_pend  = mip[11:0] & mie[11:0];
  assign unused_hi = ^{mip[31:12], mie[31:12]};

  priv_trap_prio_enc u_prio (
    .exc_vec     (exc_vec),
    .int_pend    (int_pend),
    .mstatus_mie (mstatus_mie),
    .valid       (enc_valid),
    .is_int      (enc_is_int),
    .code        (enc_code)
  );

  assign event_det = (state_q == ST_IDLE) && (enc_valid || mret);
  assign busy      = (state_q != ST_IDLE) || event_det;
  assign intr      = (kind_q == KIND_INT);

  // Event payload is only meaningful while a sequence is in flight.
  always_ff @(posedge CLK) begin
    if (event_det) begin
      code_q  <= enc_code;
      epc_q   <= epc;
      mtval_q <= mtval_in;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q           <= ST_IDLE;
      kind_q            <= KIND_NONE;
      mcause_rup        <= 1'b0;
      mepc_rup          <= 1'b0;
      mtval_rup         <= 1'b0;
      mstatus_rup       <= 1'b0;
      mcause_next       <= 32'd0;
      mepc_next         <= 32'd0;
      mtval_next        <= 32'd0;
      mstatus_mie_next  <= 1'b0;
      mstatus_mpie_next <= 1'b0;
      insert_pc         <= 1'b0;
    end else begin
      mcause_rup        <= 1'b0;
      mepc_rup          <= 1'b0;
      mtval_rup         <= 1'b0;
      mstatus_rup       <= 1'b0;
      mcause_next       <= 32'd0;
      mepc_next         <= 32'd0;
      mtval_next        <= 32'd0;
      mstatus_mie_next  <= 1'b0;
      mstatus_mpie_next <= 1'b0;
      insert_pc         <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (event_det) begin
            state_q <= ST_DRAIN;
            if (enc_valid) kind_q <= enc_is_int ? KIND_INT : KIND_EXC;
            else           kind_q <= KIND_RET;
          end
        end
        // CSR write values are registered here so they appear as a COMMIT pulse.
        ST_DRAIN: begin
          if (pipe_clear) begin
            state_q <= ST_COMMIT;
            if (kind_q == KIND_RET) begin
              mstatus_rup       <= 1'b1;
              mstatus_mie_next  <= mstatus_mpie;
              mstatus_mpie_next <= 1'b1;
            end else begin
              mcause_rup        <= 1'b1;
              mepc_rup          <= 1'b1;
              mtval_rup         <= 1'b1;
              mstatus_rup       <= 1'b1;
              mcause_next       <= {(kind_q == KIND_INT), 26'd0, code_q};
              mepc_next         <= epc_q;
              mtval_next        <= (kind_q == KIND_EXC) ? mtval_q : 32'd0;
              mstatus_mie_next  <= 1'b0;
              mstatus_mpie_next <= mstatus_mie;
            end
          end
        end
        ST_COMMIT: begin
          state_q   <= ST_REDIRECT;
          insert_pc <= 1'b1;
        end
        ST_REDIRECT: begin
          state_q <= ST_IDLE;
          kind_q  <= KIND_NONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // mret target uses mepc as seen in the redirect cycle itself.
  always_comb begin
    priv_pc = RESET_PC;
    if (state_q == ST_REDIRECT) begin
      case (kind_q)
        KIND_EXC: priv_pc = trap_base(mtvec);
        KIND_INT: priv_pc = (mtvec[1:0] == 2'b01) ? trap_vector(mtvec, code_q) : trap_base(mtvec);
        KIND_RET: priv_pc = mepc;
        default:  priv_pc = RESET_PC;
      endcase
    end
  end

endmodule

// File: tb/tb_priv_trap_sequencer.sv
// Directed bench for priv_trap_sequencer: exception, interrupt and mret
// sequences, arbitration, drain stalls and reset abort.
module tb_priv_trap_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [15:0] exc_vec;
  logic [31:0] mip, mie;
  logic        mstatus_mie, mstatus_mpie, mret, pipe_clear;
  logic [31:0] epc, mtval_in, mtvec, mepc;
  logic        busy, intr;
  logic        mcause_rup, mepc_rup, mtval_rup, mstatus_rup;
  logic [31:0] mcause_next, mepc_next, mtval_next;
  logic        mstatus_mie_next, mstatus_mpie_next;
  logic        insert_pc;
  logic [31:0] priv_pc;

  int errors = 0;
  int checks = 0;

  priv_trap_sequencer #(.RESET_PC(32'h0000_0200)) dut (
    .CLK(CLK), .nRST(nRST), .exc_vec(exc_vec), .mip(mip), .mie(mie),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .mret(mret),
    .pipe_clear(pipe_clear), .epc(epc), .mtval_in(mtval_in), .mtvec(mtvec),
    .mepc(mepc), .busy(busy), .intr(intr), .mcause_rup(mcause_rup),
    .mepc_rup(mepc_rup), .mtval_rup(mtval_rup), .mstatus_rup(mstatus_rup),
    .mcause_next(mcause_next), .mepc_next(mepc_next), .mtval_next(mtval_next),
    .mstatus_mie_next(mstatus_mie_next), .mstatus_mpie_next(mstatus_mpie_next),
    .insert_pc(insert_pc), .priv_pc(priv_pc)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_events();
    exc_vec = 16'h0;
    mip     = 32'h0;
    mret    = 1'b0;
  endtask

  // Call in the IDLE cycle in which the event inputs are presented.
  task automatic run_trap(input string tag, input logic [31:0] exp_cause, input logic [31:0] exp_epc,
                          input logic [31:0] exp_mtval, input logic exp_mpie, input logic exp_intr,
                          input logic [31:0] exp_pc);
    chk({tag, ".busy_det"}, busy, 1);
    tick();
    clear_events();
    chk({tag, ".busy_drain"}, busy, 1);
    chk({tag, ".intr"}, intr, exp_intr);
    chk({tag, ".early_rup"}, mcause_rup, 0);
    tick();
    chk({tag, ".mcause_rup"}, mcause_rup, 1);
    chk({tag, ".mepc_rup"}, mepc_rup, 1);
    chk({tag, ".mtval_rup"}, mtval_rup, 1);
    chk({tag, ".mstatus_rup"}, mstatus_rup, 1);
    chk({tag, ".mcause"}, mcause_next, exp_cause);
    chk({tag, ".mepc"}, mepc_next, exp_epc);
    chk({tag, ".mtval"}, mtval_next, exp_mtval);
    chk({tag, ".mie_next"}, mstatus_mie_next, 0);
    chk({tag, ".mpie_next"}, mstatus_mpie_next, exp_mpie);
    chk({tag, ".insert_early"}, insert_pc, 0);
    tick();
    chk({tag, ".insert_pc"}, insert_pc, 1);
    chk({tag, ".priv_pc"}, priv_pc, exp_pc);
    chk({tag, ".rup_cleared"}, mcause_rup, 0);
    tick();
    chk({tag, ".idle_busy"}, busy, 0);
    chk({tag, ".insert_cleared"}, insert_pc, 0);
  endtask

  initial begin
    int busy_cnt, rup_cnt, ins_cnt;
    logic [31:0] seen_cause;

    nRST = 1'b0;
    clear_events();
    mie = 32'h0; mstatus_mie = 1'b1; mstatus_mpie = 1'b0; pipe_clear = 1'b1;
    epc = 32'h0; mtval_in = 32'h0; mtvec = 32'h800; mepc = 32'h0;
    #22;
    chk("rst.busy", busy, 0);
    chk("rst.mcause_rup", mcause_rup, 0);
    chk("rst.insert_pc", insert_pc, 0);
    chk("rst.priv_pc", priv_pc, 32'h200);
    chk("rst.intr", intr, 0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // Illegal instruction.
    exc_vec = 16'h0004; epc = 32'h104; mtval_in = 32'hDEAD;
    #1;
    run_trap("illegal", 32'h2, 32'h104, 32'hDEAD, 1'b1, 1'b0, 32'h800);

    // Breakpoint outranks illegal; misaligned load outranks load fault.
    exc_vec = 16'h000C;
    #1;
    run_trap("bp_vs_ill", 32'h3, 32'h104, 32'hDEAD, 1'b1, 1'b0, 32'h800);
    exc_vec = 16'h0030;
    #1;
    run_trap("mall_vs_fltl", 32'h4, 32'h104, 32'hDEAD, 1'b1, 1'b0, 32'h800);

    // Exception wins over a simultaneous mret.
    exc_vec = 16'h0004; mret = 1'b1;
    #1;
    run_trap("exc_vs_mret", 32'h2, 32'h104, 32'hDEAD, 1'b1, 1'b0, 32'h800);

    // MEI + MTI, vectored mtvec: 0x800 + 11*4.
    mtvec = 32'h801; epc = 32'h300;
    mip = 32'h0000_0880; mie = 32'h0000_0880;
    #1;
    run_trap("mei", 32'h8000_000B, 32'h300, 32'h0, 1'b1, 1'b1, 32'h82C);

    // Same interrupts with mstatus.MIE clear: nothing happens.
    mstatus_mie = 1'b0;
    mip = 32'h0000_0880;
    #1;
    chk("int_masked.busy", busy, 0);
    rup_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      rup_cnt += int'(mcause_rup) + int'(mstatus_rup) + int'(insert_pc);
    end
    chk("int_masked.activity", rup_cnt, 0);
    chk("int_masked.busy_after", busy, 0);
    clear_events();

    // mret.
    mepc = 32'h2000; mstatus_mpie = 1'b1; mret = 1'b1;
    #1;
    chk("mret.busy_det", busy, 1);
    tick();
    clear_events();
    chk("mret.intr", intr, 0);
    tick();
    chk("mret.mstatus_rup", mstatus_rup, 1);
    chk("mret.mcause_rup", mcause_rup, 0);
    chk("mret.mepc_rup", mepc_rup, 0);
    chk("mret.mtval_rup", mtval_rup, 0);
    chk("mret.mie_next", mstatus_mie_next, 1);
    chk("mret.mpie_next", mstatus_mpie_next, 1);
    tick();
    chk("mret.insert_pc", insert_pc, 1);
    chk("mret.priv_pc", priv_pc, 32'h2000);
    tick();
    chk("mret.idle", busy, 0);

    // Drain stall of five cycles, with a late exception that must be ignored.
    mtvec = 32'h800; mstatus_mie = 1'b1;
    exc_vec = 16'h0004; pipe_clear = 1'b0; epc = 32'h104;
    #1;
    busy_cnt = 0; rup_cnt = 0; ins_cnt = 0; seen_cause = 32'hFFFF_FFFF;
    for (int i = 0; i < 12; i++) begin
      busy_cnt += int'(busy);
      rup_cnt  += int'(mcause_rup);
      ins_cnt  += int'(insert_pc);
      if (mcause_rup) seen_cause = mcause_next;
      tick();
      case (i)
        0: exc_vec = 16'h0000;
        1: exc_vec = 16'h0008;
        3: exc_vec = 16'h0000;
        4: pipe_clear = 1'b1;
        default: ;
      endcase
    end
    chk("stall.busy_cycles", busy_cnt, 8);
    chk("stall.strobes", rup_cnt, 1);
    chk("stall.inserts", ins_cnt, 1);
    chk("stall.cause", seen_cause, 32'h2);

    // Reset during DRAIN aborts the sequence.
    exc_vec = 16'h0004;
    #1;
    tick();
    clear_events();
    chk("rstmid.busy_drain", busy, 1);
    nRST = 1'b0;
    #1;
    chk("rstmid.busy", busy, 0);
    chk("rstmid.mcause_rup", mcause_rup, 0);
    chk("rstmid.mstatus_rup", mstatus_rup, 0);
    chk("rstmid.insert_pc", insert_pc, 0);
    chk("rstmid.priv_pc", priv_pc, 32'h200);
    @(negedge CLK);
    nRST = 1'b1;
    rup_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      rup_cnt += int'(mcause_rup) + int'(mstatus_rup) + int'(insert_pc) + int'(busy);
    end
    chk("rstmid.quiet", rup_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
